ls_mem_ctrl: RTL and testbench

//  Sequences one load/store from the Load/Store FU outputs onto the single-port data-memory bus.
//  - Takes address, size, misalign flag, zero-extend flag and store data at the EXE->MEM boundary.
//  - Runs the dm_req/dm_ack handshake and produces byte enables and lane-replicated store data.
//  - Aligns, sign- or zero-extends load data; returns the result or an exception to the MEM stage.

---
 rtl/ls_mem_ctrl_pkg.sv | 12 +
 rtl/ls_mem_ctrl_lane_align.sv | 70 +++++++
 rtl/ls_mem_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_ls_mem_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ls_mem_ctrl_pkg.sv
// Shared types and constants for the load/store memory controller.
// The LS_MISALIGN_SPLIT_EN build uses the REQ2 state; the default build never enters it.
package ls_mem_ctrl_pkg;

   typedef enum logic [1:0] {IDLE, REQ1, REQ2, RSP} LS_STATE_T;

   localparam logic [3:0] LD_ADDR_MISALIGN = 4'd4;
   localparam logic [3:0] LD_ACCESS_FAULT  = 4'd5;
   localparam logic [3:0] ST_ADDR_MISALIGN = 4'd6;
   localparam logic [3:0] ST_ACCESS_FAULT  = 4'd7;

endpackage

// File: rtl/ls_mem_ctrl_lane_align.sv
// Combinational byte-lane steering: byte enables, store lanes and load alignment/extension.
// With LS_MISALIGN_SPLIT_EN a second word's enables and read data are handled for word-crossing accesses.
module ls_mem_ctrl_lane_align (
   input  logic [1:0]  addr_lo_i,
   input  logic [2:0]  size_i,
   input  logic        zero_ext_i,
   input  logic [31:0] st_data_i,
   input  logic [31:0] rd_lo_i,
`ifdef LS_MISALIGN_SPLIT_EN
   input  logic        mis_i,
   input  logic [31:0] rd_hi_i,
   output logic [3:0]  be_hi_o,
   output logic        cross_o,
`endif
   output logic [3:0]  be_o,
   output logic [31:0] wr_data_o,
   output logic [31:0] ld_data_o
);

   logic [31:0] shifted;
   logic [31:0] repl;
`ifdef LS_MISALIGN_SPLIT_EN
   logic [3:0]  bytes;
   logic [7:0]  mask8;
   logic [63:0] rot64;
   logic [63:0] merged;
`endif

   always_comb begin
      unique case (size_i)
         3'd1:    repl = {4{st_data_i[7:0]}};
         3'd2:    repl = {2{st_data_i[15:0]}};
         default: repl = st_data_i;
      endcase

`ifdef LS_MISALIGN_SPLIT_EN
      unique case (size_i)
         3'd1:    bytes = 4'b0001;
         3'd2:    bytes = 4'b0011;
         default: bytes = 4'b1111;
      endcase
      mask8   = {4'b0000, bytes} << addr_lo_i;
      be_o    = mask8[3:0];
      be_hi_o = mask8[7:4];
      cross_o = |mask8[7:4];
      // A rotated word serves both halves of a split store: each half's enables pick its own lanes.
      rot64     = {st_data_i, st_data_i} << {addr_lo_i, 3'b000};
      wr_data_o = mis_i ? rot64[63:32] : repl;
      merged    = {rd_hi_i, rd_lo_i} >> {addr_lo_i, 3'b000};
      shifted   = merged[31:0];
`else
      unique case (size_i)
         3'd1:    be_o = 4'b0001 << addr_lo_i;
         3'd2:    be_o = 4'b0011 << {addr_lo_i[1], 1'b0};
         default: be_o = 4'b1111;
      endcase
      wr_data_o = repl;
      shifted   = rd_lo_i >> {addr_lo_i, 3'b000};
`endif

      unique case (size_i)
         3'd1:    ld_data_o = zero_ext_i ? {24'd0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
         3'd2:    ld_data_o = zero_ext_i ? {16'd0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
         default: ld_data_o = shifted;
      endcase
   end

endmodule

// File: rtl/ls_mem_ctrl.sv
// Load/store sequencer: accepts one request, runs the dm_req/dm_ack handshake, returns data or an exception.
// Define LS_MISALIGN_SPLIT_EN to execute misaligned accesses in hardware (one or two bus accesses).
module ls_mem_ctrl
   import ls_mem_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned TO_W           = 7
) (
   input  logic        clk_in,
   input  logic        reset_n_in,
   input  logic        ls_valid_in,
   output logic        ls_ready_out,
   input  logic        ls_is_st_in,
   input  logic [31:0] ls_addr_in,
   input  logic [2:0]  ls_size_in,
   input  logic        ls_mis_in,
   input  logic        ls_zero_ext_in,
   input  logic [31:0] ls_st_data_in,
   output logic        rsp_valid_out,
   output logic [31:0] rsp_ld_data_out,
   output logic        rsp_exc_out,
   output logic [3:0]  rsp_exc_code_out,
   output logic        dm_req_out,
   output logic        dm_rw_out,
   output logic [31:0] dm_addr_out,
   output logic [3:0]  dm_be_out,
   output logic [31:0] dm_wr_data_out,
   input  logic        dm_ack_in,
   input  logic [31:0] dm_rd_data_in,
   input  logic        dm_err_in
);

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   LS_STATE_T        state_q, state_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

   logic             is_st_q, zext_q;
   logic [31:0]      addr_q, st_data_q, rd_lo_q;
   logic [2:0]       size_q;
   logic             exc_q, exc_d;
   logic [3:0]       code_q, code_d;
   logic             accept, cap_lo;

   logic [3:0]       be_lo;
   logic [31:0]      wr_lanes, ld_data;
   logic [31:0]      word_addr;

`ifdef LS_MISALIGN_SPLIT_EN
   logic             mis_q, cap_hi, cross;
   logic [31:0]      rd_hi_q;
   logic [3:0]       be_hi;
`endif

   assign word_addr = {addr_q[31:2], 2'b00};

   ls_mem_ctrl_lane_align u_align (
      .addr_lo_i  (addr_q[1:0]),
      .size_i     (size_q),
      .zero_ext_i (zext_q),
      .st_data_i  (st_data_q),
      .rd_lo_i    (rd_lo_q),
`ifdef LS_MISALIGN_SPLIT_EN
      .mis_i      (mis_q),
      .rd_hi_i    (rd_hi_q),
      .be_hi_o    (be_hi),
      .cross_o    (cross),
`endif
      .be_o       (be_lo),
      .wr_data_o  (wr_lanes),
      .ld_data_o  (ld_data)
   );

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state_q  <= IDLE;
         to_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         to_cnt_q <= to_cnt_d;
      end
   end

   // Request, read-data and response payload registers only matter while the FSM qualifies them.
   always_ff @(posedge clk_in) begin
      if (accept) begin
         is_st_q   <= ls_is_st_in;
         addr_q    <= ls_addr_in;
         size_q    <= ls_size_in;
         zext_q    <= ls_zero_ext_in;
         st_data_q <= ls_st_data_in;
`ifdef LS_MISALIGN_SPLIT_EN
         mis_q     <= ls_mis_in;
`endif
      end
      if (cap_lo) rd_lo_q <= dm_rd_data_in;
`ifdef LS_MISALIGN_SPLIT_EN
      if (cap_hi) rd_hi_q <= dm_rd_data_in;
`endif
      exc_q  <= exc_d;
      code_q <= code_d;
   end

   always_comb begin
      state_d          = state_q;
      to_cnt_d         = '0;
      accept           = 1'b0;
      cap_lo           = 1'b0;
`ifdef LS_MISALIGN_SPLIT_EN
      cap_hi           = 1'b0;
`endif
      exc_d            = exc_q;
      code_d           = code_q;
      ls_ready_out     = 1'b0;
      rsp_valid_out    = 1'b0;
      rsp_ld_data_out  = '0;
      rsp_exc_out      = 1'b0;
      rsp_exc_code_out = '0;
      dm_req_out       = 1'b0;
      dm_rw_out        = 1'b0;
      dm_addr_out      = '0;
      dm_be_out        = '0;
      dm_wr_data_out   = '0;

      unique case (state_q)
         IDLE: begin
            ls_ready_out = 1'b1;
            if (ls_valid_in) begin
               accept  = 1'b1;
               exc_d   = 1'b0;
               state_d = REQ1;
`ifndef LS_MISALIGN_SPLIT_EN
               if (ls_mis_in) begin
                  exc_d   = 1'b1;
                  code_d  = ls_is_st_in ? ST_ADDR_MISALIGN : LD_ADDR_MISALIGN;
                  state_d = RSP;
               end
`endif
            end
         end

         REQ1: begin
            dm_req_out     = 1'b1;
            dm_rw_out      = is_st_q;
            dm_addr_out    = word_addr;
            dm_be_out      = be_lo;
            dm_wr_data_out = wr_lanes;
            if (dm_ack_in) begin
               if (dm_err_in) begin
                  exc_d   = 1'b1;
                  code_d  = is_st_q ? ST_ACCESS_FAULT : LD_ACCESS_FAULT;
                  state_d = RSP;
               end else begin
                  cap_lo  = 1'b1;
`ifdef LS_MISALIGN_SPLIT_EN
                  state_d = cross ? REQ2 : RSP;
`else
                  state_d = RSP;
`endif
               end
            end else if (to_cnt_q == TO_LAST) begin
               exc_d   = 1'b1;
               code_d  = is_st_q ? ST_ACCESS_FAULT : LD_ACCESS_FAULT;
               state_d = RSP;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end

`ifdef LS_MISALIGN_SPLIT_EN
         REQ2: begin
            dm_req_out     = 1'b1;
            dm_rw_out      = is_st_q;
            dm_addr_out    = word_addr + 32'd4;
            dm_be_out      = be_hi;
            dm_wr_data_out = wr_lanes;
            if (dm_ack_in) begin
               if (dm_err_in) begin
                  exc_d  = 1'b1;
                  code_d = is_st_q ? ST_ACCESS_FAULT : LD_ACCESS_FAULT;
               end else begin
                  cap_hi = 1'b1;
               end
               state_d = RSP;
            end else if (to_cnt_q == TO_LAST) begin
               exc_d   = 1'b1;
               code_d  = is_st_q ? ST_ACCESS_FAULT : LD_ACCESS_FAULT;
               state_d = RSP;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
`endif

         RSP: begin
            rsp_valid_out    = 1'b1;
            rsp_exc_out      = exc_q;
            rsp_exc_code_out = exc_q ? code_q : 4'd0;
            rsp_ld_data_out  = (exc_q || is_st_q) ? 32'd0 : ld_data;
            state_d          = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ls_mem_ctrl.sv
// Directed and randomized bench for ls_mem_ctrl with a bus responder and a byte-level reference model.
// Covers both builds; the LS_MISALIGN_SPLIT_EN build swaps the misaligned cases for a split-access check.
module tb_ls_mem_ctrl;

   localparam int TO = 64;

   logic        clk_in = 1'b0;
   logic        reset_n_in;
   logic        ls_valid_in;
   logic        ls_ready_out;
   logic        ls_is_st_in;
   logic [31:0] ls_addr_in;
   logic [2:0]  ls_size_in;
   logic        ls_mis_in;
   logic        ls_zero_ext_in;
   logic [31:0] ls_st_data_in;
   logic        rsp_valid_out;
   logic [31:0] rsp_ld_data_out;
   logic        rsp_exc_out;
   logic [3:0]  rsp_exc_code_out;
   logic        dm_req_out;
   logic        dm_rw_out;
   logic [31:0] dm_addr_out;
   logic [3:0]  dm_be_out;
   logic [31:0] dm_wr_data_out;
   logic        dm_ack_in;
   logic [31:0] dm_rd_data_in;
   logic        dm_err_in;

   int errors = 0;
   int checks = 0;

   always #5 clk_in = ~clk_in;

   ls_mem_ctrl #(.TIMEOUT_CYCLES(TO), .TO_W(7)) dut (
      .clk_in           (clk_in),
      .reset_n_in       (reset_n_in),
      .ls_valid_in      (ls_valid_in),
      .ls_ready_out     (ls_ready_out),
      .ls_is_st_in      (ls_is_st_in),
      .ls_addr_in       (ls_addr_in),
      .ls_size_in       (ls_size_in),
      .ls_mis_in        (ls_mis_in),
      .ls_zero_ext_in   (ls_zero_ext_in),
      .ls_st_data_in    (ls_st_data_in),
      .rsp_valid_out    (rsp_valid_out),
      .rsp_ld_data_out  (rsp_ld_data_out),
      .rsp_exc_out      (rsp_exc_out),
      .rsp_exc_code_out (rsp_exc_code_out),
      .dm_req_out       (dm_req_out),
      .dm_rw_out        (dm_rw_out),
      .dm_addr_out      (dm_addr_out),
      .dm_be_out        (dm_be_out),
      .dm_wr_data_out   (dm_wr_data_out),
      .dm_ack_in        (dm_ack_in),
      .dm_rd_data_in    (dm_rd_data_in),
      .dm_err_in        (dm_err_in)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference model: bytes touched, lane contents and extended load value from plain arithmetic.
   function automatic logic [3:0] exp_be(input logic [31:0] a, input int sz);
      logic [7:0] m;
      m = ((8'd1 << sz) - 8'd1) << (a % 4);
      return m[3:0];
   endfunction

   function automatic logic [31:0] exp_wr(input logic [31:0] d, input int sz);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] exp_ld(input logic [31:0] a, input int sz, input bit zx,
                                          input logic [31:0] w);
      logic [31:0] sh, mask, v;
      sh   = w >> (8 * (a % 4));
      mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
      v    = sh & mask;
      if (!zx && sz < 4 && sh[8*sz-1]) v = v | ~mask;
      return v;
   endfunction

   task automatic run_access(input bit st, input logic [31:0] a, input int sz, input bit zx,
                             input bit mis, input logic [31:0] d, input int dly, input bit err,
                             input logic [31:0] rdw);
      bit          bus, exp_exc;
      logic [3:0]  exp_code;
      logic [31:0] exp_data;
      int          hi;
      chk("ready_before", ls_ready_out, 1);
      ls_valid_in    = 1'b1;
      ls_is_st_in    = st;
      ls_addr_in     = a;
      ls_size_in     = 3'(sz);
      ls_zero_ext_in = zx;
      ls_mis_in      = mis;
      ls_st_data_in  = d;
      @(negedge clk_in);
      ls_valid_in    = 1'b0;
`ifdef LS_MISALIGN_SPLIT_EN
      bus = 1'b1;
`else
      bus = !mis;
`endif
      exp_code = 4'd0;
      if (!bus) begin
         chk("mis_no_req", dm_req_out, 0);
         exp_exc  = 1'b1;
         exp_code = st ? 4'd6 : 4'd4;
      end else if (dly >= TO) begin
         hi = 0;
         for (int k = 0; k < TO; k++) begin
            if (dm_req_out) hi++;
            @(negedge clk_in);
         end
         chk("to_req_cycles", hi, TO);
         chk("to_req_drop", dm_req_out, 0);
         dm_ack_in = 1'b1;
         exp_exc   = 1'b1;
         exp_code  = st ? 4'd7 : 4'd5;
      end else begin
         for (int k = 0; k <= dly; k++) begin
            chk("req", dm_req_out, 1);
            chk("rw", dm_rw_out, st);
            chk("addr", dm_addr_out, {a[31:2], 2'b00});
            chk("be", dm_be_out, exp_be(a, sz));
            if (st) chk("wr_data", dm_wr_data_out, exp_wr(d, sz));
            chk("ready_busy", ls_ready_out, 0);
            chk("no_early_rsp", rsp_valid_out, 0);
            if (k == dly) begin
               dm_ack_in     = 1'b1;
               dm_err_in     = err;
               dm_rd_data_in = rdw;
            end
            @(negedge clk_in);
            dm_ack_in     = 1'b0;
            dm_err_in     = 1'b0;
            dm_rd_data_in = $urandom;
         end
         exp_exc = err;
         if (err) exp_code = st ? 4'd7 : 4'd5;
      end
      exp_data = (exp_exc || st) ? 32'd0 : exp_ld(a, sz, zx, rdw);
      chk("rsp_valid", rsp_valid_out, 1);
      chk("rsp_exc", rsp_exc_out, exp_exc);
      chk("rsp_data", rsp_ld_data_out, exp_data);
      if (exp_exc) chk("rsp_code", rsp_exc_code_out, exp_code);
      chk("ready_rsp", ls_ready_out, 0);
      @(negedge clk_in);
      dm_ack_in = 1'b0;
      chk("rsp_pulse_end", rsp_valid_out, 0);
      chk("idle_no_req", dm_req_out, 0);
   endtask

   initial begin
      int          sz;
      logic [31:0] a;
      reset_n_in     = 1'b0;
      ls_valid_in    = 1'b0;
      ls_is_st_in    = 1'b0;
      ls_addr_in     = '0;
      ls_size_in     = 3'd4;
      ls_mis_in      = 1'b0;
      ls_zero_ext_in = 1'b0;
      ls_st_data_in  = '0;
      dm_ack_in      = 1'b0;
      dm_rd_data_in  = '0;
      dm_err_in      = 1'b0;

      @(negedge clk_in);
      chk("rst_ready", ls_ready_out, 1);
      chk("rst_rsp_valid", rsp_valid_out, 0);
      chk("rst_req", dm_req_out, 0);
      chk("rst_be", dm_be_out, 0);
      chk("rst_addr", dm_addr_out, 0);
      chk("rst_exc", rsp_exc_out, 0);
      reset_n_in = 1'b1;
      @(negedge clk_in);

      run_access(0, 32'h100, 4, 0, 0, 32'h0, 0, 0, 32'hDEADBEEF);
      run_access(0, 32'h103, 1, 0, 0, 32'h0, 0, 0, 32'h80FFFFFF);
      run_access(0, 32'h103, 1, 1, 0, 32'h0, 1, 0, 32'h80FFFFFF);
      run_access(1, 32'h202, 2, 0, 0, 32'h1234ABCD, 3, 0, 32'h0);
      run_access(0, 32'h402, 2, 0, 0, 32'h0, 2, 0, 32'h8001_7F00);
      run_access(0, 32'h402, 2, 1, 0, 32'h0, 0, 0, 32'h8001_7F00);

`ifdef LS_MISALIGN_SPLIT_EN
      ls_valid_in = 1'b1;
      ls_is_st_in = 1'b0;
      ls_addr_in  = 32'h101;
      ls_size_in  = 3'd4;
      ls_mis_in   = 1'b1;
      @(negedge clk_in);
      ls_valid_in = 1'b0;
      chk("split_req1", dm_req_out, 1);
      chk("split_addr1", dm_addr_out, 32'h100);
      chk("split_be1", dm_be_out, 4'b1110);
      dm_ack_in = 1'b1;
      dm_rd_data_in = 32'hAABBCCDD;
      @(negedge clk_in);
      chk("split_req2", dm_req_out, 1);
      chk("split_addr2", dm_addr_out, 32'h104);
      chk("split_be2", dm_be_out, 4'b0001);
      dm_rd_data_in = 32'h11223344;
      @(negedge clk_in);
      dm_ack_in = 1'b0;
      chk("split_rsp_valid", rsp_valid_out, 1);
      chk("split_rsp_data", rsp_ld_data_out, 32'h44AABBCC);
      chk("split_rsp_exc", rsp_exc_out, 0);
      @(negedge clk_in);
      ls_mis_in = 1'b0;
`else
      run_access(0, 32'h101, 4, 0, 1, 32'h0, 0, 0, 32'h0);
      run_access(1, 32'h102, 4, 0, 1, 32'h55AA55AA, 0, 0, 32'h0);
`endif

      run_access(0, 32'h500, 4, 0, 0, 32'h0, TO, 0, 32'h0);
      run_access(1, 32'h504, 4, 0, 0, 32'hCAFEF00D, TO, 0, 32'h0);
      run_access(0, 32'h600, 4, 0, 0, 32'h0, 1, 1, 32'h12345678);
      run_access(1, 32'h601, 1, 0, 0, 32'h000000EE, 0, 1, 32'h0);

      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(0, 2))
            0:       sz = 1;
            1:       sz = 2;
            default: sz = 4;
         endcase
         a = $urandom & ~(32'(sz) - 32'd1);
         run_access(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), 0, $urandom,
                    $urandom_range(0, 3), ($urandom_range(0, 7) == 0), $urandom);
      end

      ls_valid_in = 1'b1;
      ls_is_st_in = 1'b0;
      ls_addr_in  = 32'h300;
      ls_size_in  = 3'd4;
      @(negedge clk_in);
      ls_valid_in = 1'b0;
      chk("pre_rst_req", dm_req_out, 1);
      reset_n_in = 1'b0;
      #1;
      chk("async_rst_req", dm_req_out, 0);
      chk("async_rst_ready", ls_ready_out, 1);
      chk("async_rst_rsp", rsp_valid_out, 0);
      @(negedge clk_in);
      @(negedge clk_in);
      reset_n_in = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_in);
         chk("post_rst_rsp", rsp_valid_out, 0);
         chk("post_rst_ready", ls_ready_out, 1);
         chk("post_rst_req", dm_req_out, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
